// File: rtl/negbus_iop_rx.sv
// Receiver for the ground-true negative-level I/O bus: synchronizes IOP, device-select
// and AC lines, filters glitches, decodes the select and emits one-clock IOP strobes.
module negbus_iop_rx #(
    parameter logic [5:0]  DEV_CODE = 6'o00,
    parameter int unsigned FILTER   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  bus_iop_n,
    input  logic [5:0]  bus_ds_n,
    input  logic [11:0] bus_ac_n,
    input  logic        err_clr,
    output logic [2:0]  iop_stb,
    output logic [11:0] ac_data,
    output logic        busy,
    output logic        err
);

    localparam logic [3:0] FILT = FILTER[3:0];
    localparam int         SW   = 21;

    typedef enum logic [1:0] {IDLE, QUAL, ACTIVE, REL} state_t;

    logic [SW-1:0] sync1_q, sync2_q;
    logic [2:0]    iop;
    logic [5:0]    ds;
    logic [11:0]   ac;
    logic          sel, any;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d, cnt_inc;
    logic [2:0]    pat_q, pat_d;
    logic          qualify;
    logic [2:0]    stb_q, stb_d;
    logic [11:0]   ac_q, ac_d;
    logic          err_q, err_d, err_set;

    // Synchronizers reset to the deasserted (high) bus level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= {bus_ac_n, bus_ds_n, bus_iop_n};
            sync2_q <= sync1_q;
        end
    end

    assign iop     = ~sync2_q[2:0];
    assign ds      = ~sync2_q[8:3];
    assign ac      = ~sync2_q[20:9];
    assign sel     = (ds == DEV_CODE);
    assign any     = |iop;
    assign cnt_inc = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pat_q   <= '0;
            stb_q   <= '0;
            ac_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            stb_q   <= stb_d;
            ac_q    <= ac_d;
            err_q   <= err_d;
        end
    end

    // The cycle that latches the pattern already counts as the first stable cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        qualify = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (any && sel) begin
                    pat_d = iop;
                    cnt_d = 4'd1;
                    if (FILT <= 4'd1) begin
                        state_d = ACTIVE;
                        qualify = 1'b1;
                    end else begin
                        state_d = QUAL;
                    end
                end
            end
            QUAL: begin
                if (iop == pat_q && sel) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= FILT) begin
                        state_d = ACTIVE;
                        qualify = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            ACTIVE: begin
                if (!any) begin
                    if (FILT <= 4'd1) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = REL;
                        cnt_d   = 4'd1;
                    end
                end
            end
            REL: begin
                if (any) begin
                    state_d = ACTIVE;
                    cnt_d   = '0;
                end else if (cnt_inc >= FILT) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        stb_d   = qualify ? pat_d : 3'b000;
        ac_d    = qualify ? ac : ac_q;
        err_set = (state_q == ACTIVE) && ((|(iop & ~pat_q)) || (any && !sel));
        err_d   = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
        busy    = (state_q == ACTIVE) || (state_q == REL);
    end

    assign iop_stb = stb_q;
    assign ac_data = ac_q;
    assign err     = err_q;

endmodule

// File: doc/negbus_iop_rx.md
# negbus_iop_rx

Receive-side converter for the negative-level I/O bus: takes the ground-true IOP pulse lines, device-select lines and AC data lines that the processor drives out, and turns them into clean, synchronous, positive-logic strobes for one peripheral. It synchronizes the inputs, rejects glitches, decodes the device select and emits one-clock IOP strobes with captured bus data. It sits between the bus connector pins and a peripheral's control logic.

## Interface
- DEV_CODE, 6'o00, device select code (MB bits 3:8) this instance responds to
- FILTER, 4, consecutive stable cycles required to accept an assertion or release (1..15)
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high; clears all state
- bus_iop_n  input  3  IOP1/IOP2/IOP4 lines, bit0=IOP1; 0 = asserted (ground-true)
- bus_ds_n  input  6  device select lines, MB3..MB8, ground-true
- bus_ac_n  input  12  AC data lines, ground-true
- iop_stb  output  3  one-cycle strobe per IOP, positive logic
- ac_data  output  12  AC captured at qualification, positive logic (inverted from bus)
- busy  output  1  high from qualification until release completes
- err  output  1  sticky overlap/select-change error
- err_clr  input  1  synchronous clear of err

## Operation
- All bus inputs pass through a 2-flop synchronizer, then are inverted to positive logic (iop, ds, ac).
- sel = (ds == DEV_CODE); any = |iop.
- FSM states: IDLE, QUAL, ACTIVE, REL.
- IDLE: cnt=0. If any && sel, latch pattern p = iop and go QUAL with cnt=1.
- QUAL: if iop == p && sel, cnt++; on cnt reaching FILTER go ACTIVE. Otherwise (glitch, pattern change, select lost), return to IDLE with no strobe and no error.
- Entry to ACTIVE (the cycle the FSM is in QUAL and cnt reaches FILTER): iop_stb = p for exactly one cycle; ac_data <= ac; busy <= 1.
- ACTIVE: if iop has a bit set that is not in p, or sel drops while any, set err. If iop == 0, go REL with cnt=1.
- REL: iop == 0 for FILTER cycles -> IDLE, busy <= 0. Any reassertion before that returns to ACTIVE with cnt=0 and no new strobe.
- p with several bits set (simultaneous IOPs) is legal: the strobes for all set bits fire in the same cycle.
- err: set as above. err_clr clears it. Set wins when set and clear occur in the same cycle.
- ac_data holds its value until the next qualification.

## Timing
- Reset values: iop_stb=0, ac_data=0, busy=0, err=0, FSM=IDLE, cnt=0, synchronizer flops=all-deasserted (1 on the _n side).
- Latency: bus assertion edge to iop_stb = 2 (sync) + FILTER cycles. busy rises in the same cycle as iop_stb.
- Minimum accepted pulse width: FILTER cycles after synchronization. Shorter pulses produce nothing.
- busy falls 2 + FILTER cycles after the bus release edge.
- Back-to-back IOPs (IOP1 then IOP2 with a gap of at least FILTER cycles) produce two separate strobes. The second strobe must not occur until after REL has completed.
- Reset asserted mid-pulse: outputs clear immediately. After reset deasserts with the pulse still on the bus, the pulse is requalified and strobes once.
- cnt is 4 bits and saturates; it must not wrap.

## Test plan
- DEV_CODE=6'o34, FILTER=4. Drive ds=34, IOP1 low for 10 cycles, AC=12'o5252 -> iop_stb=3'b001 for one cycle, 6 cycles after the edge; ac_data=12'o5252; busy high until 6 cycles after release.
- Same setup with a 3-cycle IOP2 pulse -> no strobe, busy stays 0, err stays 0.
- ds=12 (no match) with a 10-cycle IOP4 pulse -> no strobe.
- IOP1 active, then IOP2 asserted during ACTIVE -> single IOP1 strobe, err=1. Pulse err_clr with no new event -> err=0.
- IOP1 for 8 cycles, 6-cycle gap, then IOP4 for 8 cycles -> strobes 001 then 100, each one cycle long.
- Assert reset during ACTIVE with IOP2 held; release reset -> all outputs 0 during reset, then one IOP2 strobe 6 cycles after reset deasserts.
